regfile_write_arbiter: RTL and testbench

- Shares the single register-file write port (write_reg / write_data / reg_write_en) between two writeback sources.
- Requester 0 is the single-cycle ALU path; requester 1 is the multi-cycle memory/long-latency path.
- Each source is buffered in a small FIFO. Fair round-robin arbitration issues at most one register write per cycle through a registered output stage.
- Exports a pending-write scoreboard so decode can stall on outstanding destination registers.

---
 rtl/regfile_write_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Two-source register-file writeback arbiter: per-source FIFOs, round-robin grant,
// registered write port, and a pending-destination mask for decode stalls.

module rfwa_fifo #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 64,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  input  logic [ADDR_W-1:0] rd_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic              ready_o,
  output logic              nonempty_o,
  output logic [ADDR_W-1:0] head_rd_o,
  output logic [DATA_W-1:0] head_data_o,
  output logic [31:0]       pend_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][ADDR_W-1:0] rd_q;
  logic [DEPTH-1:0][DATA_W-1:0] data_q;
  logic [PW-1:0]                wptr_q, rptr_q;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic [DEPTH-1:0]             occ;
  logic                         push;

  assign ready_o     = cnt_q < CW'(DEPTH);
  // x0 writes are acknowledged but dropped here so they never occupy a slot
  assign push        = valid_i & ready_o & (rd_i != '0);
  assign nonempty_o  = cnt_q != '0;
  assign head_rd_o   = rd_q[rptr_q];
  assign head_data_o = data_q[rptr_q];

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop_i})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (push)  wptr_q <= wptr_q + PW'(1);
      if (pop_i) rptr_q <= rptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      rd_q[wptr_q]   <= rd_i;
      data_q[wptr_q] <= data_i;
    end
  end

  // slot i is live when its distance from the read pointer is below the count
  always_comb begin
    occ = '0;
    for (int i = 0; i < DEPTH; i++)
      occ[i] = {1'b0, PW'(i) - rptr_q} < cnt_q;
  end

  always_comb begin
    pend_o = '0;
    for (int i = 0; i < DEPTH; i++)
      for (int r = 1; r < 32; r++)
        if (occ[i] && rd_q[i] == ADDR_W'(r)) pend_o[r] = 1'b1;
  end
endmodule

module regfile_write_arbiter #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_rd,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_rd,
  input  logic [DATA_W-1:0] req1_data,
  output logic [ADDR_W-1:0] rf_write_reg,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              rf_reg_write_en,
  output logic [31:0]       pending_mask,
  output logic              idle
);
  localparam int NREQ = 2;

  logic [NREQ-1:0]             vld, rdy, nonempty, gnt;
  logic [NREQ-1:0][ADDR_W-1:0] rd_in, head_rd;
  logic [NREQ-1:0][DATA_W-1:0] data_in, head_data;
  logic [NREQ-1:0][31:0]       pend;
  logic [31:0]                 stage_pend;

  logic              en_q;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] wreg_q, wreg_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  assign vld     = {req1_valid, req0_valid};
  assign rd_in   = {req1_rd, req0_rd};
  assign data_in = {req1_data, req0_data};
  assign req0_ready = rdy[0];
  assign req1_ready = rdy[1];

  for (genvar g = 0; g < NREQ; g++) begin : g_req
    rfwa_fifo #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .valid_i     (vld[g]),
      .rd_i        (rd_in[g]),
      .data_i      (data_in[g]),
      .pop_i       (gnt[g]),
      .ready_o     (rdy[g]),
      .nonempty_o  (nonempty[g]),
      .head_rd_o   (head_rd[g]),
      .head_data_o (head_data[g]),
      .pend_o      (pend[g])
    );
  end

  // under contention the side that did not win last time goes next
  assign gnt[0] = nonempty[0] & (~nonempty[1] | last_q);
  assign gnt[1] = nonempty[1] & (~nonempty[0] | ~last_q);

  always_comb begin
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    last_d  = last_q;
    if (gnt[0]) begin
      wreg_d  = head_rd[0];
      wdata_d = head_data[0];
      last_d  = 1'b0;
    end else if (gnt[1]) begin
      wreg_d  = head_rd[1];
      wdata_d = head_data[1];
      last_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_q    <= 1'b0;
      wreg_q  <= '0;
      wdata_q <= '0;
      last_q  <= 1'b1;
    end else begin
      en_q    <= |gnt;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    stage_pend = '0;
    for (int r = 1; r < 32; r++)
      if (en_q && wreg_q == ADDR_W'(r)) stage_pend[r] = 1'b1;
  end

  assign rf_write_reg    = wreg_q;
  assign rf_write_data   = wdata_q;
  assign rf_reg_write_en = en_q;
  assign pending_mask    = (pend[0] | pend[1] | stage_pend) & ~32'd1;
  assign idle            = ~nonempty[0] & ~nonempty[1] & ~en_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: write scoreboard, regfile model, vector table
// and hand sequences for reset flush, contention and push/pop overlap.

module tb_regfile_write_arbiter;
  localparam int DW = 64;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [AW-1:0] req0_rd, req1_rd, rf_write_reg;
  logic [DW-1:0] req0_data, req1_data, rf_write_data;
  logic          rf_reg_write_en, idle;
  logic [31:0]   pending_mask;

  regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rd(req0_rd), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rd(req1_rd), .req1_data(req1_data),
    .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data), .rf_reg_write_en(rf_reg_write_en),
    .pending_mask(pending_mask), .idle(idle)
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] rd; logic [DW-1:0] data; } wr_t;
  typedef struct { bit who; logic [AW-1:0] rd; logic [DW-1:0] data; } vec_t;

  wr_t         exp_q[$];
  logic [DW-1:0] rf [32] = '{default: '0};
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // register file model: commits on the edge that ends an enabled cycle
  always @(posedge clk)
    if (rf_reg_write_en && rf_write_reg != '0) rf[rf_write_reg] <= rf_write_data;

  always @(negedge clk) begin : mon
    wr_t e;
    if (rf_reg_write_en) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_write: got rd=%0d data=%h want none", rf_write_reg, rf_write_data);
      end else begin
        e = exp_q.pop_front();
        chk("wr_rd", 64'(rf_write_reg), 64'(e.rd));
        chk("wr_data", rf_write_data, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_exp(input logic [AW-1:0] rd, input logic [DW-1:0] data);
    wr_t w;
    w.rd = rd; w.data = data;
    exp_q.push_back(w);
  endtask

  function automatic logic [DW-1:0] pat(input int rd);
    return {32'hC0DE0000 + 32'(rd), ~32'(rd)};
  endfunction

  task automatic drain();
    int n = 0;
    while (!(idle && exp_q.size() == 0) && n < 50) begin tick(); n++; end
    chk("drain_timeout", 64'(n < 50), 64'd1);
  endtask

  vec_t vt[6];
  int   ord[8] = '{2, 10, 3, 11, 4, 12, 5, 13};

  initial begin
    logic [31:0] m;
    logic [DW-1:0] ev;
    int i0, i1;
    bit a0, a1;
    req0_valid = 0; req1_valid = 0;
    req0_rd = '0; req1_rd = '0; req0_data = '0; req1_data = '0;

    repeat (2) tick();
    @(negedge clk);
    chk("rst_idle", 64'(idle), 64'd1);
    chk("rst_en", 64'(rf_reg_write_en), 64'd0);
    chk("rst_wreg", 64'(rf_write_reg), 64'd0);
    chk("rst_wdata", rf_write_data, 64'd0);
    chk("rst_mask", 64'(pending_mask), 64'd0);
    chk("rst_ready0", 64'(req0_ready), 64'd1);
    chk("rst_ready1", 64'(req1_ready), 64'd1);
    tick(); rst_n = 1;

    // single req0 write to x1: timing and pending window
    req0_valid = 1; req0_rd = 5'd1; req0_data = 64'hDEADBEEFDEADBEEF;
    chk("s_ready0", 64'(req0_ready), 64'd1);
    push_exp(5'd1, 64'hDEADBEEFDEADBEEF);
    tick(); req0_valid = 0;
    @(negedge clk);
    chk("s_en_c0", 64'(rf_reg_write_en), 64'd0);
    chk("s_mask_c0", 64'(pending_mask), 64'h2);
    tick(); @(negedge clk);
    chk("s_en_c1", 64'(rf_reg_write_en), 64'd1);
    chk("s_mask_c1", 64'(pending_mask), 64'h2);
    tick(); @(negedge clk);
    chk("s_en_c2", 64'(rf_reg_write_en), 64'd0);
    chk("s_mask_c2", 64'(pending_mask), 64'h0);
    chk("s_x1", rf[1], 64'hDEADBEEFDEADBEEF);
    tick();

    // reset with entries buffered in both FIFOs discards them
    req0_valid = 1; req0_rd = 5'd1;  req0_data = 64'hAAAAAAAAAAAAAAAA;
    req1_valid = 1; req1_rd = 5'd20; req1_data = 64'hBBBBBBBBBBBBBBBB;
    tick(); req0_valid = 0; req1_valid = 0; rst_n = 0;
    @(negedge clk);
    chk("rf_mask_pre", 64'(pending_mask), 64'h0010_0002);
    chk("rf_idle_pre", 64'(idle), 64'd0);
    tick(); rst_n = 1;
    @(negedge clk);
    chk("rf_idle", 64'(idle), 64'd1);
    chk("rf_mask", 64'(pending_mask), 64'd0);
    chk("rf_en", 64'(rf_reg_write_en), 64'd0);
    chk("rf_ready0", 64'(req0_ready), 64'd1);
    chk("rf_ready1", 64'(req1_ready), 64'd1);
    repeat (3) tick();
    chk("rf_x1_old", rf[1], 64'hDEADBEEFDEADBEEF);
    chk("rf_x20_old", rf[20], 64'd0);

    // isolated vectors, including x0 from both sides
    vt[0] = '{1'b0, 5'd0,  64'hFFFFFFFFFFFFFFFF};
    vt[1] = '{1'b1, 5'd7,  64'h0123456789ABCDEF};
    vt[2] = '{1'b0, 5'd31, 64'h5555555555555555};
    vt[3] = '{1'b1, 5'd0,  64'h1111111111111111};
    vt[4] = '{1'b0, 5'd7,  64'h0F0F0F0F0F0F0F0F};
    vt[5] = '{1'b1, 5'd15, 64'h8000000000000001};
    for (int k = 0; k < 6; k++) begin
      if (vt[k].who) begin
        req1_valid = 1; req1_rd = vt[k].rd; req1_data = vt[k].data;
        chk("v_ready1", 64'(req1_ready), 64'd1);
      end else begin
        req0_valid = 1; req0_rd = vt[k].rd; req0_data = vt[k].data;
        chk("v_ready0", 64'(req0_ready), 64'd1);
      end
      if (vt[k].rd != '0) push_exp(vt[k].rd, vt[k].data);
      m  = (vt[k].rd != '0) ? (32'd1 << vt[k].rd) : 32'd0;
      ev = (vt[k].rd != '0) ? vt[k].data : 64'd0;
      tick(); req0_valid = 0; req1_valid = 0;
      @(negedge clk);
      chk("v_mask", 64'(pending_mask), 64'(m));
      chk("v_idle", 64'(idle), 64'(vt[k].rd == '0));
      tick(); @(negedge clk);
      chk("v_en", 64'(rf_reg_write_en), 64'(vt[k].rd != '0));
      repeat (2) tick();
      chk("v_rf", rf[vt[k].rd], ev);
      chk("v_idle_end", 64'(idle), 64'd1);
    end

    // continuous contention from reset: strict alternation, no gaps, req1 backpressure
    rst_n = 0; tick(); rst_n = 1;
    for (int k = 0; k < 8; k++) push_exp(5'(ord[k]), pat(ord[k]));
    i0 = 0; i1 = 0;
    for (int c = 0; c < 12; c++) begin
      if (c >= 2 && c <= 9) chk("c_no_gap", 64'(rf_reg_write_en), 64'd1);
      if (c == 10) chk("c_en_end", 64'(rf_reg_write_en), 64'd0);
      req0_valid = (i0 < 4); req0_rd = 5'(2 + i0);  req0_data = pat(2 + i0);
      req1_valid = (i1 < 4); req1_rd = 5'(10 + i1); req1_data = pat(10 + i1);
      if (c == 2) begin
        chk("c_fill_ready1", 64'(req1_ready), 64'd0);
        chk("c_fill_ready0", 64'(req0_ready), 64'd1);
      end
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      tick();
      if (a0) i0++;
      if (a1) i1++;
    end
    req0_valid = 0; req1_valid = 0;
    chk("c_all_acc0", 64'(i0), 64'd4);
    chk("c_all_acc1", 64'(i1), 64'd4);
    drain();

    // req1 push on the same edge its FIFO pops: count holds, order kept
    req1_valid = 1; req1_rd = 5'd30; req1_data = 64'h3030303030303030;
    push_exp(5'd30, 64'h3030303030303030);
    tick();
    req1_rd = 5'd31; req1_data = 64'h1234567890ABCDEF;
    chk("pp_ready_a", 64'(req1_ready), 64'd1);
    push_exp(5'd31, 64'h1234567890ABCDEF);
    tick(); req1_valid = 0;
    chk("pp_ready_b", 64'(req1_ready), 64'd1);
    chk("pp_mask_b", 64'(pending_mask), 64'hC000_0000);
    chk("pp_idle_b", 64'(idle), 64'd0);
    tick();
    chk("pp_en", 64'(rf_reg_write_en), 64'd1);
    chk("pp_mask_c", 64'(pending_mask), 64'h8000_0000);
    drain();
    chk("pp_x31", rf[31], 64'h1234567890ABCDEF);
    chk("pp_x0", rf[0], 64'd0);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
